seq_detect_ctrl: RTL and testbench

Sequencer for the "1011" Moore sequence detector. The block takes a parallel word via a start strobe and shifts it MSB-first into an embedded detector, one bit per cycle. It counts detector matches over the word and reports the count with a one-cycle done pulse. It sits between a word-oriented producer and the bit-serial detector datapath, and optionally keeps the detector state from one word to the next.

---
 rtl/seq_detect_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serializes a parallel word MSB-first into an embedded
// "1011" Moore detector and counts detector matches over the word.
// A one-cycle done pulse marks match_count as final for that word.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             keep,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             ser_j,
    output logic             det_w
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        C_IDLE,
        C_SHIFT,
        C_FLUSH,
        C_DONE
    } ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S1,
        S10,
        S101,
        S1011
    } det_t;

    ctrl_t            ctrl_q;
    ctrl_t            ctrl_nxt;
    det_t             det_q;
    det_t             det_step;
    det_t             det_nxt;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             kill;
    logic             det_clear;
    logic             count_en;

    // Handshake qualifiers: start only in IDLE, abort only while shifting/flushing
    always_comb begin
        accept    = (ctrl_q == C_IDLE) && start;
        kill      = abort && ((ctrl_q == C_SHIFT) || (ctrl_q == C_FLUSH));
        det_clear = (accept && !keep) || kill;
        // First SHIFT cycle excluded so a match carried over via keep is not counted twice
        count_en  = det_w && (((ctrl_q == C_SHIFT) && (bit_cnt != LAST)) ||
                              (ctrl_q == C_FLUSH));
        ser_j     = (ctrl_q == C_SHIFT) && sr[WIDTH-1];
        det_w     = (det_q == S1011);
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= C_IDLE;
        end else begin
            ctrl_q <= ctrl_nxt;
        end
    end

    // Controller next-state and status outputs
    always_comb begin
        ctrl_nxt = ctrl_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (ctrl_q)
            C_IDLE: begin
                if (start) begin
                    ctrl_nxt = C_SHIFT;
                end
            end
            C_SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    ctrl_nxt = C_IDLE;
                end else if (bit_cnt == '0) begin
                    ctrl_nxt = C_FLUSH;
                end
            end
            C_FLUSH: begin
                busy     = 1'b1;
                ctrl_nxt = abort ? C_IDLE : C_DONE;
            end
            C_DONE: begin
                done     = 1'b1;
                ctrl_nxt = C_IDLE;
            end
            default: ctrl_nxt = C_IDLE;
        endcase
    end

    // Detector state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q <= S_IDLE;
        end else begin
            det_q <= det_nxt;
        end
    end

    // Detector next-state: advances on ser_j only in SHIFT, otherwise holds
    always_comb begin
        det_step = det_q;
        case (det_q)
            S_IDLE:  det_step = ser_j ? S1    : S_IDLE;
            S1:      det_step = ser_j ? S1    : S10;
            S10:     det_step = ser_j ? S101  : S_IDLE;
            S101:    det_step = ser_j ? S1011 : S10;
            S1011:   det_step = ser_j ? S1    : S10;
            default: det_step = S_IDLE;
        endcase
        det_nxt = det_q;
        if (det_clear) begin
            det_nxt = S_IDLE;
        end else if (ctrl_q == C_SHIFT) begin
            det_nxt = det_step;
        end
    end

    // Shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sr      <= din;
            bit_cnt <= LAST;
        end else if (ctrl_q == C_SHIFT) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Saturating match counter, cleared on accept and on abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (accept || kill) begin
            match_count <= '0;
        end else if (count_en && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: directed words with hand-computed match
// counts; expectations are queued at start and checked at each done pulse.
module tb_seq_detect_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             keep;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;
    logic             ser_j;
    logic             det_w;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        int               at;
    } exp_t;

    exp_t sbq[$];

    seq_detect_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .din         (din),
        .keep        (keep),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .match_count (match_count),
        .ser_j       (ser_j),
        .det_w       (det_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check("match_count", int'(match_count), int'(e.cnt));
                check("done_cycle", cyc, e.at);
            end
        end
    end

    // Present a word in an IDLE cycle; returns #1 after the accepting edge (cycle 1)
    task automatic launch(input logic [WIDTH-1:0] w, input logic k,
                          input bit push, input logic [CNT_W-1:0] exp);
        @(negedge clk);
        start = 1'b1;
        din   = w;
        keep  = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sbq.push_back('{exp, cyc + WIDTH + 1});
    endtask

    task automatic wait_word();
        repeat (WIDTH + 2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_count"}, int'(match_count), 0);
        check({tag, "_ser_j"}, int'(ser_j), 0);
        check({tag, "_det_w"}, int'(det_w), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        keep  = 1'b0;
        abort = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single match, with busy profile over cycles 1..10
        launch(8'b1011_0000, 1'b0, 1'b1, 4'd1);
        for (int k = 1; k <= WIDTH + 2; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), int'(busy), (k <= WIDTH + 1) ? 1 : 0);
        end

        // Overlapping matches, then no match
        launch(8'b1011_0110, 1'b0, 1'b1, 4'd2);
        wait_word();
        launch(8'b1111_1111, 1'b0, 1'b1, 4'd0);
        wait_word();

        // Cross-word carry with keep, then the same word without keep
        launch(8'b0000_0101, 1'b0, 1'b1, 4'd0);
        wait_word();
        launch(8'b1000_0000, 1'b1, 1'b1, 4'd1);
        wait_word();
        launch(8'b1000_0000, 1'b0, 1'b1, 4'd0);
        wait_word();

        // start pulsed in cycle 3 must be ignored
        launch(8'b1011_0000, 1'b0, 1'b1, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (WIDTH) @(negedge clk);
        check("ignored_start_busy", int'(busy), 0);
        check("ignored_start_count", int'(match_count), 1);

        // Abort in cycle 5: back to IDLE with no done
        launch(8'b1011_1011, 1'b0, 1'b0, 4'd0);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(match_count), 0);
        repeat (WIDTH + 2) @(negedge clk);
        check("abort_after_count", int'(match_count), 0);

        // Asynchronous reset in SHIFT cycle 4
        launch(8'b1011_0000, 1'b0, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_ser_j", int'(ser_j), 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        launch(8'b1011_1011, 1'b0, 1'b1, 4'd2);
        wait_word();
        @(negedge clk);

        check("pending_done", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
